pulse_burst_gen: RTL and testbench

- Generates a gated pulse train that drives the clock input of the downstream feedback counter.
- Stops when the counter's feedback line deasserts.
- Runs entirely in the sysclk domain and guarantees that every pulse edge is a registered, glitch-free output.
- Provides a start/busy/done handshake to the controlling sequencer, plus a pulse count and a timeout error for runaway bursts.

---
 rtl/pulse_burst_gen.sv | 135 +++++++++++++
 tb/tb_pulse_burst_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_gen.sv
// rtl/pulse_burst_gen.sv - gated pulse train for a feedback counter, with start/busy/done handshake.
// Optional macro PULSE_BURST_FB_SYNC_EN adds a 2-flop synchronizer on feedBack.
module pulse_burst_gen #(
  parameter int HALF_PERIOD = 4,
  parameter int MAX_PULSES  = 16,
  parameter int CNT_W       = 5
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             start,
  input  logic             feedBack,
  output logic             pulseOut,
  output logic             busy,
  output logic             done,
  output logic             timeoutErr,
  output logic [CNT_W-1:0] pulseCount
);

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PH_W-1:0]  PH_RELOAD = PH_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_PULSES);

  generate
    if (HALF_PERIOD < 2 || HALF_PERIOD > 255) begin : g_bad_half_period
      $error("pulse_burst_gen: HALF_PERIOD must be within 2..255");
    end
    if (MAX_PULSES < 1 || MAX_PULSES >= (2 ** CNT_W)) begin : g_bad_max_pulses
      $error("pulse_burst_gen: CNT_W too narrow for MAX_PULSES");
    end
  endgenerate

  logic fb_use;

`ifdef PULSE_BURST_FB_SYNC_EN
  generate
    if (HALF_PERIOD < 4) begin : g_bad_sync_half_period
      $error("pulse_burst_gen: synchronized feedback needs HALF_PERIOD >= 4");
    end
  endgenerate

  logic [1:0] fb_sync;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      fb_sync <= 2'b00;
    end else begin
      fb_sync <= {fb_sync[0], feedBack};
    end
  end

  assign fb_use = fb_sync[1];
`else
  assign fb_use = feedBack;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  phase_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             to_nxt;

  always_comb begin
    state_nxt = state;
    phase_nxt = (phase != '0) ? phase - PH_W'(1) : phase;
    cnt_nxt   = pulseCount;
    to_nxt    = timeoutErr;
    case (state)
      IDLE: begin
        if (start && fb_use) begin
          state_nxt = HIGH;
          phase_nxt = PH_RELOAD;
          cnt_nxt   = '0;
          to_nxt    = 1'b0;
        end
      end
      HIGH: begin
        if (phase == '0) begin
          state_nxt = LOW;
          phase_nxt = PH_RELOAD;
          cnt_nxt   = pulseCount + CNT_W'(1);
        end
      end
      LOW: begin
        // Feedback is only trusted on the last low cycle, after the counter has settled.
        if (phase == '0) begin
          if (!fb_use) begin
            state_nxt = FIN;
          end else if (pulseCount == CNT_MAX) begin
            state_nxt = FIN;
            to_nxt    = 1'b1;
          end else begin
            state_nxt = HIGH;
            phase_nxt = PH_RELOAD;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are flops decoded from the next state so every pulse edge is glitch-free.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      phase      <= '0;
      pulseCount <= '0;
      timeoutErr <= 1'b0;
      pulseOut   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      pulseCount <= cnt_nxt;
      timeoutErr <= to_nxt;
      pulseOut   <= (state_nxt == HIGH);
      busy       <= (state_nxt == HIGH) || (state_nxt == LOW);
      done       <= (state_nxt == FIN);
    end
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb/tb_pulse_burst_gen.sv - directed scoreboard bench for pulse_burst_gen.
module tb_pulse_burst_gen;

  localparam int HP   = 4;
  localparam int MAXP = 16;
  localparam int CW   = 5;
`ifdef PULSE_BURST_FB_SYNC_EN
  localparam int SYNC_LAT = 1;
  localparam int K_SIX    = 1;
  localparam int K_FIVE   = 3;
`else
  localparam int SYNC_LAT = 0;
  localparam int K_SIX    = -1;
  localparam int K_FIVE   = 1;
`endif

  logic          sysclk = 1'b0;
  logic          reset;
  logic          start;
  logic          feedBack;
  logic          pulseOut;
  logic          busy;
  logic          done;
  logic          timeoutErr;
  logic [CW-1:0] pulseCount;

  always #5 sysclk = ~sysclk;

  pulse_burst_gen #(
    .HALF_PERIOD(HP),
    .MAX_PULSES (MAXP),
    .CNT_W      (CW)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .start     (start),
    .feedBack  (feedBack),
    .pulseOut  (pulseOut),
    .busy      (busy),
    .done      (done),
    .timeoutErr(timeoutErr),
    .pulseCount(pulseCount)
  );

  typedef struct {
    int   cnt;
    logic to;
    int   cyc;
  } exp_t;

  exp_t sb[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mcnt     = 0;
  int   target   = 8;
  int   hi_run   = 0;
  int   lo_run   = 0;
  int   n_fall   = 0;
  int   n_done   = 0;
  logic fb_model = 1'b0;
  logic fb_force = 1'b1;
  logic fb_pipe  = 1'b1;
  logic prev_po  = 1'b0;
  logic have_fall = 1'b0;
  logic wchk     = 1'b1;
  logic any_busy = 1'b0;
  logic any_po   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sysclk cycle: sample outputs on the falling edge, track pulse widths, advance the counter model.
  task automatic tick();
    @(negedge sysclk);
    cyc++;
    if (done) n_done++;
    if (busy) any_busy = 1'b1;
    if (pulseOut) any_po = 1'b1;
    if (pulseOut) begin
      if (!prev_po && have_fall && wchk) check("low_width", lo_run, HP);
      if (!prev_po) hi_run = 0;
      hi_run++;
    end else begin
      if (prev_po) begin
        n_fall++;
        mcnt++;
        have_fall = 1'b1;
        lo_run = 0;
        if (wchk) check("high_width", hi_run, HP);
      end
      lo_run++;
    end
    prev_po = pulseOut;
    if (fb_model) begin
      feedBack = fb_pipe;
      fb_pipe  = (mcnt < target);
    end else begin
      feedBack = fb_force;
    end
  endtask

  task automatic start_burst(input int cnt, input logic to, input int dcyc);
    exp_t e;
    e.cnt = cnt;
    e.to  = to;
    e.cyc = dcyc;
    sb.push_back(e);
    start     = 1'b1;
    cyc       = 0;
    n_fall    = 0;
    have_fall = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    exp_t e;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) break;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_count"}, pulseCount, e.cnt);
      check({tag, "_edges"}, n_fall, e.cnt);
      check({tag, "_timeout"}, timeoutErr, e.to);
      check({tag, "_done_cycle"}, cyc, e.cyc);
      check({tag, "_busy_at_done"}, busy, 1'b0);
    end
    n_fall    = 0;
    have_fall = 1'b0;
  endtask

  task automatic fb_drop_run(input int k, input int exp_n, input string tag);
    start_burst(exp_n, 1'b0, 2 * HP * exp_n + 1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && n_fall < 5; i++) tick();
    repeat (HP - k - 1) tick();
    fb_force = 1'b0;
    feedBack = 1'b0;
    wait_done(200, tag);
    fb_force = 1'b1;
    feedBack = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    feedBack = 1'b1;

    repeat (3) tick();
    check("rst_pulseOut", pulseOut, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeoutErr", timeoutErr, 1'b0);
    check("rst_pulseCount", pulseCount, 0);
    reset = 1'b1;
    repeat (4) tick();

    // Counter model releases feedBack after 8 falling edges.
    mcnt     = 0;
    target   = 8;
    fb_pipe  = 1'b1;
    fb_model = 1'b1;
    n_done   = 0;
    start_burst(8, 1'b0, 2 * HP * 8 + 1);
    tick();
    start = 1'b0;
    check("t1_pulse_c1", pulseOut, 1'b1);
    check("t1_busy_c1", busy, 1'b1);
    wait_done(200, "t1");
    tick();
    check("t1_busy_after", busy, 1'b0);
    check("t1_done_width", done, 1'b0);
    check("t1_done_once", n_done, 1);

    // Stuck-high feedback runs into the pulse limit.
    fb_model = 1'b0;
    fb_force = 1'b1;
    repeat (3) tick();
    n_done = 0;
    start_burst(MAXP, 1'b1, 2 * HP * MAXP + 1);
    tick();
    start = 1'b0;
    wait_done(400, "t2");
    repeat (5) tick();
    check("t2_done_once", n_done, 1);
    check("t2_timeout_sticky", timeoutErr, 1'b1);

    // Start with feedBack low is ignored.
    fb_force = 1'b0;
    repeat (3) tick();
    any_busy = 1'b0;
    any_po   = 1'b0;
    n_done   = 0;
    start    = 1'b1;
    repeat (8) tick();
    start = 1'b0;
    check("t3_no_busy", any_busy, 1'b0);
    check("t3_no_pulse", any_po, 1'b0);
    check("t3_no_done", n_done, 0);
    check("t3_count_held", pulseCount, MAXP);
    check("t3_timeout_held", timeoutErr, 1'b1);

    // start held across two bursts; counter model cleared at the first done.
    mcnt     = 0;
    target   = 8;
    fb_pipe  = 1'b1;
    fb_model = 1'b1;
    repeat (3) tick();
    n_done = 0;
    start_burst(8, 1'b0, 2 * HP * 8 + 1);
    begin
      exp_t e2;
      e2.cnt = 8;
      e2.to  = 1'b0;
      e2.cyc = 2 * (2 * HP * 8 + 1) + 1 + SYNC_LAT;
      sb.push_back(e2);
    end
    tick();
    check("t5_timeout_cleared", timeoutErr, 1'b0);
    check("t5_count_cleared", pulseCount, 0);
    wait_done(200, "t5a");
    mcnt     = 0;
    fb_pipe  = 1'b1;
    feedBack = 1'b1;
    tick();
    check("t5_idle_gap", pulseOut, 1'b0);
    if (SYNC_LAT > 0) begin
      tick();
      check("t5_idle_gap_sync", pulseOut, 1'b0);
    end
    tick();
    check("t5_restart", pulseOut, 1'b1);
    start = 1'b0;
    wait_done(200, "t5b");
    repeat (4) tick();
    check("t5_done_twice", n_done, 2);

    // Reset during the third high phase.
    fb_model = 1'b0;
    fb_force = 1'b1;
    repeat (3) tick();
    wchk      = 1'b0;
    n_fall    = 0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !(n_fall == 2 && pulseOut); i++) tick();
    tick();
    check("t4_in_high", pulseOut, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("t4_async_pulseOut", pulseOut, 1'b0);
    check("t4_async_count", pulseCount, 0);
    check("t4_async_busy", busy, 1'b0);
    tick();
    reset  = 1'b1;
    n_done = 0;
    repeat (6) tick();
    check("t4_no_done", n_done, 0);
    check("t4_idle_busy", busy, 1'b0);
    check("t4_idle_pulse", pulseOut, 1'b0);
    wchk = 1'b1;

    // feedBack drop around the last low cycle of pulse 5.
    fb_drop_run(K_SIX, 6, "t6_late");
    fb_drop_run(K_FIVE, 5, "t6_early");

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
